display_scan_driver: RTL and testbench

Time-multiplexed 4-digit seven-segment driver that consumes the display timing produced by the display clock divider. It latches hex/BCD digit values and cycles the common anodes through them at a parameterised slot rate. Each slot begins with a blanking gap to suppress ghosting. New values are applied only at frame boundaries, so a refresh never shows a mix of old and new digits.

---
 rtl/display_pkg.sv | 30 +++
 rtl/hex_to_seg.sv | 32 +++
 rtl/display_scan_driver.sv | 141 ++++++++++++++
 tb/tb_display_scan_driver.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment scan driver: active-high segment patterns {g,f,e,d,c,b,a}.
// Optional build macro used by the top: LEADING_ZERO_BLANK_EN.
package display_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Maps an active-high segment pattern onto the board's pin polarity.
  function automatic logic [6:0] seg_pol(input logic [6:0] seg_hi, input logic active_low);
    return active_low ? ~seg_hi : seg_hi;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment decoder (0-9, A, b, C, d, E, F).
// Zero latency; polarity is applied by the instantiating module.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [6:0]          seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      default: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed seven-segment scan driver; all outputs registered, one cycle behind cnt/idx.
// New digits take effect only at frame boundaries; LEADING_ZERO_BLANK_EN suppresses leading zeros.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                       clock_in,
  input  logic                       reset,
  input  logic [NIBBLE_W*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]          dp_in,
  input  logic                       load,
  output logic [6:0]                 seg_out,
  output logic                       dp_out,
  output logic [DIGITS-1:0]          an_out,
  output logic                       frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic              POL_LOW  = (ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_INACT = {7{POL_LOW}};
  localparam logic [DIGITS-1:0] AN_INACT  = {DIGITS{POL_LOW}};

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NIBBLE_W*DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [DIGITS-1:0]          pend_dp_q, pend_dp_d;
  logic [NIBBLE_W*DIGITS-1:0] disp_dig_q, disp_dig_d;
  logic [DIGITS-1:0]          disp_dp_q, disp_dp_d;

  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_q, frame_d;

  logic slot_end, frame_end, in_blank;

  assign slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));
  assign in_blank  = (32'(cnt_q) < 32'(BLANK_CYCLES));

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // A load on the boundary cycle itself goes straight through to the display copy.
  always_comb begin
    pend_dig_d = load ? digits_in : pend_dig_q;
    pend_dp_d  = load ? dp_in     : pend_dp_q;
    disp_dig_d = frame_end ? pend_dig_d : disp_dig_q;
    disp_dp_d  = frame_end ? pend_dp_d  : disp_dp_q;
  end

  logic [NIBBLE_W-1:0] nib [DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_nib
    assign nib[k] = disp_dig_q[k*NIBBLE_W +: NIBBLE_W];
  end

  logic [DIGITS-1:0] lz_blank;

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_run;

  // Zeros are blanked from the top digit down until the first nonzero; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      lz_run      = lz_run & (nib[k] == '0);
      lz_blank[k] = lz_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  logic [NIBBLE_W-1:0] cur_nib;
  logic [6:0]          seg_hi;
  logic [DIGITS-1:0]   an_hot;

  assign cur_nib = nib[idx_q];
  assign an_hot  = DIGITS'(1) << idx_q;

  hex_to_seg u_hex_to_seg (
    .nibble_i (cur_nib),
    .seg_o    (seg_hi)
  );

  always_comb begin
    seg_d   = SEG_INACT;
    dp_d    = POL_LOW;
    an_d    = AN_INACT;
    frame_d = frame_end;
    if (!in_blank) begin
      an_d  = POL_LOW ? ~an_hot : an_hot;
      seg_d = lz_blank[idx_q] ? SEG_INACT : seg_pol(seg_hi, POL_LOW);
      dp_d  = disp_dp_q[idx_q] ^ POL_LOW;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      disp_dig_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= SEG_INACT;
      dp_q       <= POL_LOW;
      an_q       <= AN_INACT;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      disp_dig_q <= disp_dig_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low outputs.
module tb_display_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld  = 1'b0;
  logic [15:0] dig = '0;
  logic [3:0]  dpi = '0;
  logic [6:0]  seg;
  logic        dpo;
  logic [3:0]  an;
  logic        fd;

  int checks   = 0;
  int failures = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = 7'h7F;
`else
  localparam logic [6:0] Z = 7'h40;
`endif

  always #5 clk = ~clk;

  display_scan_driver #(
    .DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
  ) dut (
    .clock_in   (clk),
    .reset      (rst),
    .digits_in  (dig),
    .dp_in      (dpi),
    .load       (ld),
    .seg_out    (seg),
    .dp_out     (dpo),
    .an_out     (an),
    .frame_done (fd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Walks one 32-cycle frame aligned to the scan, checking {an,seg,dp,frame_done} every cycle;
  // optionally drives up to two single-cycle loads at given cycle positions.
  task automatic run_frame(input string tag,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dpm,
                           input int la, input logic [15:0] da, input logic [3:0] pa,
                           input int lb, input logic [15:0] db, input logic [3:0] pb);
    logic [6:0] sv [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fd;
    int         c, slot;
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      c    = (i - 1) % 8;
      slot = (i - 1) / 8;
      if (c < 2) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        exp_an  = ~(4'b0001 << slot);
        exp_seg = sv[slot];
        exp_dp  = ~dpm[slot];
      end
      exp_fd = (i == 32);
      check($sformatf("%s cyc%0d {an,seg,dp,fd}", tag, i),
            {19'd0, an, seg, dpo, fd}, {19'd0, exp_an, exp_seg, exp_dp, exp_fd});
      if (i == la) begin
        ld = 1'b1; dig = da; dpi = pa;
      end else if (i == lb) begin
        ld = 1'b1; dig = db; dpi = pb;
      end else begin
        ld = 1'b0;
      end
    end
  endtask

  typedef struct {
    int         la;
    logic [15:0] da;
    logic [3:0]  pa;
    int         lb;
    logic [15:0] db;
    logic [3:0]  pb;
    logic [6:0]  s0, s1, s2, s3;
    logic [3:0]  dpm;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [6:0] p0, p1, p2, p3;
    logic [3:0] pdm;

    vt[0] = '{10, 16'h12AF, 4'b0100, 0,  16'h0000, 4'b0000, 7'h0E, 7'h08, 7'h24, 7'h79, 4'b0100};
    vt[1] = '{5,  16'h1111, 4'b0000, 20, 16'h2222, 4'b0001, 7'h24, 7'h24, 7'h24, 7'h24, 4'b0001};
    vt[2] = '{31, 16'h0005, 4'b1000, 0,  16'h0000, 4'b0000, 7'h12, Z,     Z,     Z,     4'b1000};
    vt[3] = '{3,  16'h0030, 4'b0000, 0,  16'h0000, 4'b0000, 7'h40, 7'h30, Z,     Z,     4'b0000};
    vt[4] = '{1,  16'h0000, 4'b0000, 0,  16'h0000, 4'b0000, 7'h40, Z,     Z,     Z,     4'b0000};
    vt[5] = '{16, 16'hC9B8, 4'b1111, 0,  16'h0000, 4'b0000, 7'h00, 7'h03, 7'h10, 7'h46, 4'b1111};
    vt[6] = '{7,  16'h7E4D, 4'b0000, 0,  16'h0000, 4'b0000, 7'h21, 7'h19, 7'h06, 7'h78, 4'b0000};
    vt[7] = '{25, 16'h0360, 4'b0010, 0,  16'h0000, 4'b0000, 7'h40, 7'h02, 7'h30, Z,     4'b0010};

    repeat (3) @(negedge clk);
    check("reset_state", {19'd0, an, seg, dpo, fd}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    rst = 1'b0;

    run_frame("init0", 7'h40, Z, Z, Z, 4'b0000, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    run_frame("init1", 7'h40, Z, Z, Z, 4'b0000, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    p0 = 7'h40; p1 = Z; p2 = Z; p3 = Z; pdm = 4'b0000;
    for (int v = 0; v < 8; v++) begin
      run_frame($sformatf("vec%0d_old", v), p0, p1, p2, p3, pdm,
                vt[v].la, vt[v].da, vt[v].pa, vt[v].lb, vt[v].db, vt[v].pb);
      p0 = vt[v].s0; p1 = vt[v].s1; p2 = vt[v].s2; p3 = vt[v].s3; pdm = vt[v].dpm;
    end
    run_frame("vec7_new", p0, p1, p2, p3, pdm, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    // Asynchronous reset in the middle of slot 1's drive phase.
    repeat (12) @(negedge clk);
    check("pre_reset_anode", {28'd0, an}, {28'd0, 4'b1101});
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {19'd0, an, seg, dpo, fd}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    check("reset_held", {19'd0, an, seg, dpo, fd}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    run_frame("post_rst0", 7'h40, Z, Z, Z, 4'b0000, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    run_frame("post_rst1", 7'h40, Z, Z, Z, 4'b0000, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
